// File: rtl/pipe_hazard_fwd_unit_if.sv
// ID-stage request, EX-stage operand and status bundle for pipe_hazard_fwd_unit.
// The pipeline control drives the master side; the hazard unit is the slave.
interface pipe_hazard_fwd_unit_if #(
  parameter int DATA_W = 16,
  parameter int NLANES = 2,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic                  id_valid;
  logic [REG_AW-1:0]     id_rs1;
  logic [REG_AW-1:0]     id_rs2;
  logic                  id_use1;
  logic                  id_use2;
  logic [NLANES-1:0]     id_lanes;
  logic [REG_AW-1:0]     id_rd;
  logic                  id_we;
  logic                  id_load;
  logic                  id_eop;
  logic                  flush;
  logic [DATA_W-1:0]     ex_rf1;
  logic [DATA_W-1:0]     ex_rf2;
  logic [DATA_W-1:0]     mem_data;
  logic [DATA_W-1:0]     wb_data;

  logic                  stall;
  logic                  ex_valid;
  logic [DATA_W-1:0]     ex_op1;
  logic [DATA_W-1:0]     ex_op2;
  logic [2*NLANES-1:0]   fwd1_sel;
  logic [2*NLANES-1:0]   fwd2_sel;
  logic                  halted;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      fwd_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_lanes, id_rd,
           id_we, id_load, id_eop, flush, ex_rf1, ex_rf2, mem_data, wb_data,
    input  stall, ex_valid, ex_op1, ex_op2, fwd1_sel, fwd2_sel, halted,
           stall_cnt, fwd_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_lanes, id_rd,
           id_we, id_load, id_eop, flush, ex_rf1, ex_rf2, mem_data, wb_data,
    output stall, ex_valid, ex_op1, ex_op2, fwd1_sel, fwd2_sel, halted,
           stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/pipe_hazard_fwd_unit.sv
// Load-use stall, jump flush, end-of-program halt and per-lane EX operand forwarding
// for a 5-stage pipeline. Define HAZ_STATS_EN to add saturating stall/forward counters.
module pipe_hazard_fwd_unit #(
  parameter int DATA_W = 16,
  parameter int NLANES = 2,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input logic                    clk,
  input logic                    rst,
  pipe_hazard_fwd_unit_if.slave  bus
);

  localparam int LW = DATA_W / NLANES;

  typedef enum logic [1:0] {
    SEL_RF  = 2'd0,
    SEL_MEM = 2'd1,
    SEL_WB  = 2'd2
  } fwd_sel_e;

  // EX keeps the source fields; later stages only need what a consumer matches against.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
    logic [NLANES-1:0] lanes;
    logic              use1;
    logic              use2;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } ex_slot_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic [NLANES-1:0] lanes;
  } dst_slot_t;

  ex_slot_t  ex_q,  ex_d;
  dst_slot_t mem_q, mem_d;
  dst_slot_t wb_q,  wb_d;
  logic      mem_load_q, mem_load_d;
  logic      halted_q, halted_d;

  logic                load_use;
  logic                stall;
  logic [2*NLANES-1:0] fwd1_sel;
  logic [2*NLANES-1:0] fwd2_sel;
  logic [DATA_W-1:0]   ex_op1;
  logic [DATA_W-1:0]   ex_op2;
  logic                any_fwd;

  function automatic logic [LW-1:0] lane_mux(input logic [1:0]    sel,
                                             input logic [LW-1:0] rf,
                                             input logic [LW-1:0] mem,
                                             input logic [LW-1:0] wb);
    case (fwd_sel_e'(sel))
      SEL_MEM: lane_mux = mem;
      SEL_WB:  lane_mux = wb;
      default: lane_mux = rf;
    endcase
  endfunction

  // Hazard detection and slot advance
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    load_use = 1'b0;
    stall    = 1'b0;
    ex_d     = '0;
    halted_d = halted_q;

    load_use = bus.id_valid && ex_q.valid && ex_q.load && ex_q.we &&
               (|(bus.id_lanes & ex_q.lanes)) &&
               ((bus.id_use1 && (bus.id_rs1 == ex_q.rd)) ||
                (bus.id_use2 && (bus.id_rs2 == ex_q.rd)));

    // Once halted the front end is frozen regardless of flush.
    stall = halted_q || (!bus.flush && load_use);

    if (bus.id_valid && !stall && !bus.flush && !halted_q) begin
      ex_d.valid = 1'b1;
      ex_d.rd    = bus.id_rd;
      ex_d.we    = bus.id_we;
      ex_d.load  = bus.id_load;
      ex_d.lanes = bus.id_lanes;
      ex_d.use1  = bus.id_use1;
      ex_d.use2  = bus.id_use2;
      ex_d.rs1   = bus.id_rs1;
      ex_d.rs2   = bus.id_rs2;
    end

    if (bus.id_eop && bus.id_valid && !bus.flush && !stall) begin
      halted_d = 1'b1;
    end

    mem_d.valid = ex_q.valid;
    mem_d.rd    = ex_q.rd;
    mem_d.we    = ex_q.we;
    mem_d.lanes = ex_q.lanes;
    mem_load_d  = ex_q.load;
    wb_d        = mem_q;
  end

  // Per-lane operand selection; the youngest producer (MEM) wins over WB.
  always_comb begin
    fwd1_sel = '0;
    fwd2_sel = '0;
    ex_op1   = '0;
    ex_op2   = '0;

    for (int l = 0; l < NLANES; l++) begin
      if (ex_q.valid && ex_q.use1 && ex_q.lanes[l]) begin
        if (mem_q.valid && mem_q.we && !mem_load_q && mem_q.lanes[l] && (mem_q.rd == ex_q.rs1)) begin
          fwd1_sel[2*l +: 2] = SEL_MEM;
        end else if (wb_q.valid && wb_q.we && wb_q.lanes[l] && (wb_q.rd == ex_q.rs1)) begin
          fwd1_sel[2*l +: 2] = SEL_WB;
        end
      end

      if (ex_q.valid && ex_q.use2 && ex_q.lanes[l]) begin
        if (mem_q.valid && mem_q.we && !mem_load_q && mem_q.lanes[l] && (mem_q.rd == ex_q.rs2)) begin
          fwd2_sel[2*l +: 2] = SEL_MEM;
        end else if (wb_q.valid && wb_q.we && wb_q.lanes[l] && (wb_q.rd == ex_q.rs2)) begin
          fwd2_sel[2*l +: 2] = SEL_WB;
        end
      end

      if (ex_q.valid && ex_q.lanes[l]) begin
        ex_op1[l*LW +: LW] = lane_mux(fwd1_sel[2*l +: 2], bus.ex_rf1[l*LW +: LW],
                                      bus.mem_data[l*LW +: LW], bus.wb_data[l*LW +: LW]);
        ex_op2[l*LW +: LW] = lane_mux(fwd2_sel[2*l +: 2], bus.ex_rf2[l*LW +: LW],
                                      bus.mem_data[l*LW +: LW], bus.wb_data[l*LW +: LW]);
      end
    end

    any_fwd = |{fwd1_sel, fwd2_sel};
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      mem_load_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
      mem_load_q <= mem_load_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.stall    = stall;
  assign bus.ex_valid = ex_q.valid;
  assign bus.ex_op1   = ex_op1;
  assign bus.ex_op2   = ex_op2;
  assign bus.fwd1_sel = fwd1_sel;
  assign bus.fwd2_sel = fwd2_sel;
  assign bus.halted   = halted_q;

`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q,   fwd_cnt_d;

  // Drain stalls after halt are not hazards and are left out of the count.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && !halted_q && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (any_fwd && (fwd_cnt_q != '1)) begin
      fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.fwd_cnt   = '0;
`endif

endmodule

// File: doc/pipe_hazard_fwd_unit.md
Name: pipe_hazard_fwd_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage processor pipeline: fetch, ID, EX, MEM, WB.
- Tracks destination and byte-lane metadata for the instructions in EX, MEM and WB.
- Generates per-lane forwarded EX operands from MEM-stage ALU results and WB write-back data.
- Detects load-use hazards and stalls, handles jump flush, and latches end-of-program halt.
- Replaces the fixed 2-lane, 3-bit-address hazard control with parametrised width, lane count and register depth.

Parameters:
DATA_W, 16, datapath width in bits
NLANES, 2, number of independently written byte lanes; lane width LW = DATA_W/NLANES
REG_AW, 3, register address width
CNT_W, 16, statistics counter width (used only with HAZ_STATS_EN)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
id_valid  in  1  an instruction is present in ID
id_rs1, id_rs2  in  REG_AW  source register addresses
id_use1, id_use2  in  1  the instruction reads that source
id_lanes  in  NLANES  lanes read/written by the instruction (bit l = lane l)
id_rd  in  REG_AW  destination register
id_we  in  1  the instruction writes the register file
id_load  in  1  the instruction is a memory load
id_eop  in  1  end-of-program instruction
flush  in  1  jump resolved in ID; kill the ID instruction
ex_rf1, ex_rf2  in  DATA_W  register-file operands latched into the EX stage
mem_data  in  DATA_W  ALU result held in the MEM stage
wb_data  in  DATA_W  write-back data in the WB stage
stall  out  1  hold PC and ID; insert a bubble into EX
ex_valid  out  1  EX slot holds a real instruction
ex_op1, ex_op2  out  DATA_W  forwarded, lane-masked EX operands
fwd1_sel, fwd2_sel  out  2*NLANES  per-lane source, 2 bits per lane: 0 = RF, 1 = MEM, 2 = WB
halted  out  1  sticky end-of-program flag
stall_cnt, fwd_cnt  out  CNT_W  statistics counters (only with HAZ_STATS_EN)

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Slot state:
  - Three slots (EX, MEM, WB), each holding {valid, rd, we, load, lanes, use1, use2, rs1, rs2}.
  - The EX slot holds the sources; MEM and WB hold the destination fields.
- Reset:
  - All slot valid bits = 0, halted = 0, counters = 0.
  - Consequently stall = 0, ex_valid = 0, fwd*_sel = 0 and ex_op* = 0.
- Advance, every cycle when not in reset:
  - WB takes MEM, and MEM takes EX.
  - EX takes the ID fields when id_valid & !stall & !flush & !halted; otherwise EX takes a bubble (valid = 0).
- Stall (combinational):
  - stall = id_valid & !flush & EX.valid & EX.load & EX.we & |(id_lanes & EX.lanes) & ((id_use1 & id_rs1==EX.rd) | (id_use2 & id_rs2==EX.rd)).
  - Effect: exactly one bubble per load-use pair. On the next cycle the load is in MEM and no longer matches EX.
- Flush:
  - flush has priority over stall; stall is forced to 0 when flush = 1.
  - The ID instruction never enters EX. Slots already in EX/MEM/WB are unaffected.
- Forwarding (combinational, evaluated per lane l, per source s, on the EX slot):
  - If EX.use_s & EX.lanes[l] & MEM.valid & MEM.we & MEM.lanes[l] & MEM.rd==EX.rs_s: select MEM, code 1.
  - Else if the same condition holds against the WB slot: select WB, code 2.
  - Else: select the RF operand, code 0.
  - MEM always beats WB (youngest producer wins).
  - A MEM-slot load never forwards from MEM, because its data is not ready. The stall guarantees this case cannot arise.
- Operand lanes:
  - Lane l of ex_op_s = the selected source lane when EX.valid & EX.lanes[l]; otherwise 0.
  - fwd*_sel = 0 whenever EX.valid = 0.
- Partial lane overlap: only overlapping lanes forward; the remaining lanes come from RF.
- Halt:
  - id_eop & id_valid & !flush & !stall sets halted on the next edge; it stays set until rst.
  - While halted, stall = 1 and only bubbles enter EX, so the pipeline drains within 3 cycles.
- rst asserted mid-stall or mid-flush: on that edge all slots are cleared and halted is cleared.

Optional Feature:
HAZ_STATS_EN
- Defined:
  - stall_cnt increments on each cycle where stall = 1 and halted = 0.
  - fwd_cnt increments on each cycle where EX.valid and any lane of either source selects MEM or WB.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: both counters are absent, the ports are tied to 0, and no counter logic is present.

Test Plan:
- Reset: rst = 1 for 2 cycles with id_valid = 1 → stall = 0, ex_valid = 0, ex_op1 = ex_op2 = 0, halted = 0.
- MEM forward: ALU op rd = 3, lanes = 2'b11; next cycle rs1 = 3; mem_data = 16'hA5C3 → fwd1_sel = 4'b0101, ex_op1 = 16'hA5C3.
- WB forward and priority:
  - Writers to r2 two and one cycles ahead, with wb_data = 16'h1111 and mem_data = 16'h2222; consumer rs2 = 2 → ex_op2 = 16'h2222.
  - Remove the younger writer → ex_op2 = 16'h1111, fwd2_sel = 4'b1010.
- Load-use: load rd = 5, then rs1 = 5 → stall = 1 for exactly 1 cycle, one bubble; consumer then forwards from WB with wb_data = 16'h00FF.
- Lane mask: producer lanes = 2'b01 rd = 4, consumer lanes = 2'b11 rs1 = 4, ex_rf1 = 16'hBE00, mem_data = 16'h0012 → ex_op1 = 16'hBE12.
- Flush and EOP:
  - flush together with a load-use match → stall = 0 and a bubble enters EX.
  - id_eop → halted = 1 next cycle, stall held at 1; after 3 cycles ex_valid = 0. With HAZ_STATS_EN, stall_cnt equals the counted non-halted stall cycles.
